// File: rtl/inst_fetch_pkg.sv
// Shared processor defines for the fetch unit.
// Provides the instruction width, NOP encoding, default reset PC and the IF/ID bundle.
package inst_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-to-decode valid/ready handshake.
// The master side is the fetch unit and the slave side is decode.
interface inst_fetch_if;

  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  modport master (
    output if_valid,
    output if_instr,
    output if_pc,
    input  if_ready
  );

  modport slave (
    input  if_valid,
    input  if_instr,
    input  if_pc,
    output if_ready
  );

endinterface

// File: rtl/inst_fetch_fifo.sv
// Fetch buffer: a small FIFO of {pc, instr} entries with flush.
// The head reads as {0, NOP} when empty, so no storage reset value leaks out.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  if_id_t      din,
  output if_id_t      dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  if_id_t      mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (count == CAP);

  assign dout = empty ? '{pc: '0, instr: NOP}
                      : mem[rd_ptr[AW-1:0]];

  // Pointer update; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop)  rd_ptr <= rd_ptr + ONE;
    end
  end

  // Entry storage written at the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, combinational-read memory port, fetch buffer.
// Optional perf counters fetch_cnt/flush_cnt are built when FETCH_PERF_CNT_EN is defined.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter int          MEM_AW    = 6,
  parameter int          BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [XLEN-1:0]   mem_data,
  inst_fetch_if.master      dec,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam int AW = $clog2(BUF_DEPTH);

  logic [XLEN-1:0] pc;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic            valid;
  logic [AW:0]     count;
  if_id_t          head;
  if_id_t          entry;

  assign mem_addr = pc[MEM_AW+1:2];
  assign valid    = !empty;

  assign pop  = valid && dec.if_ready && !redirect_valid;
  assign push = (!full || pop) && !redirect_valid;

  assign entry = '{pc: pc, instr: mem_data};

  assign dec.if_valid = valid;
  assign dec.if_instr = head.instr;
  assign dec.if_pc    = head.pc;

  // Fetch PC: redirect target (word aligned) or sequential advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      pc <= pc + 32'd4;
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

`ifdef FETCH_PERF_CNT_EN
  // Pushes and entries discarded by redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (push)           fetch_cnt <= fetch_cnt + 32'd1;
      if (redirect_valid) flush_cnt <= flush_cnt + 32'(count);
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch.
// Memory model returns 32'hA000_0000 + word address.
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic [5:0]  mem_addr;
  logic [31:0] mem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  int passed;
  int total;

  inst_fetch_if bus ();

  inst_fetch #(
    .RESET_PC  (32'h0),
    .MEM_AW    (6),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .dec            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  assign mem_data = 32'hA000_0000 + {26'd0, mem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.if_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    #3;
    total++;
    if (bus.if_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", bus.if_valid);
    else passed++;
    total++;
    if (bus.if_instr !== 32'h13) $display("FAIL rst_instr got %h exp 00000013", bus.if_instr);
    else passed++;
    total++;
    if (bus.if_pc !== 32'h0) $display("FAIL rst_pc got %h exp 0", bus.if_pc);
    else passed++;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (mem_addr !== 6'd0 || bus.if_valid !== 1'b0)
      $display("FAIL rst_hold addr %0d valid %b exp 0 0", mem_addr, bus.if_valid);
    else passed++;
  endtask

  task automatic test_stream();
    bus.if_ready = 1'b1;
    do_reset();
    total++;
    if (bus.if_valid !== 1'b0) $display("FAIL stream_pre got %b exp 0", bus.if_valid);
    else passed++;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(4*k) ||
          bus.if_instr !== 32'hA000_0000 + 32'(k))
        $display("FAIL stream_%0d got v%b %h %h exp v1 %h %h", k, bus.if_valid,
                 bus.if_pc, bus.if_instr, 32'(4*k), 32'hA000_0000 + 32'(k));
      else passed++;
    end
  endtask

  task automatic test_stall();
    bus.if_ready = 1'b0;
    do_reset();
    repeat (5) begin
      tick();
      total++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_instr !== 32'hA000_0000)
        $display("FAIL stall_hold got v%b %h %h exp v1 0 a0000000",
                 bus.if_valid, bus.if_pc, bus.if_instr);
      else passed++;
    end
    total++;
    if (mem_addr !== 6'd2) $display("FAIL stall_pc addr %0d exp 2", mem_addr);
    else passed++;
    bus.if_ready = 1'b1;
    tick();
    total++;
    if (bus.if_pc !== 32'h4 || bus.if_instr !== 32'hA000_0001)
      $display("FAIL stall_rel1 got %h %h exp 4 a0000001", bus.if_pc, bus.if_instr);
    else passed++;
    tick();
    total++;
    if (bus.if_pc !== 32'h8 || bus.if_instr !== 32'hA000_0002)
      $display("FAIL stall_rel2 got %h %h exp 8 a0000002", bus.if_pc, bus.if_instr);
    else passed++;
  endtask

  task automatic test_redirect();
    bus.if_ready = 1'b0;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0042;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (bus.if_valid !== 1'b0 || bus.if_instr !== 32'h13)
      $display("FAIL redir_flush got v%b %h exp v0 00000013", bus.if_valid, bus.if_instr);
    else passed++;
    total++;
    if (mem_addr !== 6'd16) $display("FAIL redir_pc addr %0d exp 16", mem_addr);
    else passed++;
    tick();
    total++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h40 || bus.if_instr !== 32'hA000_0010)
      $display("FAIL redir_target got v%b %h %h exp v1 40 a0000010",
               bus.if_valid, bus.if_pc, bus.if_instr);
    else passed++;
  endtask

  task automatic test_redirect_pop();
    bus.if_ready = 1'b0;
    do_reset();
    tick();
    tick();
    bus.if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0080;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (bus.if_valid !== 1'b0) $display("FAIL rpop_flush got %b exp 0", bus.if_valid);
    else passed++;
`ifdef FETCH_PERF_CNT_EN
    total++;
    if (flush_cnt !== 32'd2) $display("FAIL rpop_flush_cnt got %0d exp 2", flush_cnt);
    else passed++;
    total++;
    if (fetch_cnt !== 32'd2) $display("FAIL rpop_fetch_cnt got %0d exp 2", fetch_cnt);
    else passed++;
`endif
    tick();
    total++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h80 || bus.if_instr !== 32'hA000_0020)
      $display("FAIL rpop_target got v%b %h %h exp v1 80 a0000020",
               bus.if_valid, bus.if_pc, bus.if_instr);
    else passed++;
    tick();
    total++;
    if (bus.if_pc !== 32'h84 || bus.if_instr !== 32'hA000_0021)
      $display("FAIL rpop_next got %h %h exp 84 a0000021", bus.if_pc, bus.if_instr);
    else passed++;
`ifdef FETCH_PERF_CNT_EN
    total++;
    if (fetch_cnt !== 32'd4) $display("FAIL rpop_fetch_cnt2 got %0d exp 4", fetch_cnt);
    else passed++;
`endif
  endtask

  task automatic test_wrap();
    bus.if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_00F8;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (mem_addr !== 6'd62) $display("FAIL wrap_a0 addr %0d exp 62", mem_addr);
    else passed++;
    tick();
    total++;
    if (mem_addr !== 6'd63 || bus.if_pc !== 32'hF8 || bus.if_instr !== 32'hA000_003E)
      $display("FAIL wrap_1 got %0d %h %h exp 63 f8 a000003e", mem_addr, bus.if_pc, bus.if_instr);
    else passed++;
    tick();
    total++;
    if (mem_addr !== 6'd0 || bus.if_pc !== 32'hFC || bus.if_instr !== 32'hA000_003F)
      $display("FAIL wrap_2 got %0d %h %h exp 0 fc a000003f", mem_addr, bus.if_pc, bus.if_instr);
    else passed++;
    tick();
    total++;
    if (mem_addr !== 6'd1 || bus.if_pc !== 32'h100 || bus.if_instr !== 32'hA000_0000)
      $display("FAIL wrap_3 got %0d %h %h exp 1 100 a0000000", mem_addr, bus.if_pc, bus.if_instr);
    else passed++;
    tick();
    total++;
    if (bus.if_pc !== 32'h104 || bus.if_instr !== 32'hA000_0001)
      $display("FAIL wrap_4 got %h %h exp 104 a0000001", bus.if_pc, bus.if_instr);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bus.if_ready = 1'b1;
    tick();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.if_valid !== 1'b0 || bus.if_instr !== 32'h13 || bus.if_pc !== 32'h0)
      $display("FAIL rmid_async got v%b %h %h exp v0 00000013 0",
               bus.if_valid, bus.if_instr, bus.if_pc);
    else passed++;
    total++;
    if (mem_addr !== 6'd0) $display("FAIL rmid_pc addr %0d exp 0", mem_addr);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_instr !== 32'hA000_0000)
      $display("FAIL rmid_restart got v%b %h %h exp v1 0 a0000000",
               bus.if_valid, bus.if_pc, bus.if_instr);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h0000_0000, byte address fetched first after reset.
REQ-002 SHALL have parameter MEM_AW, 6, instruction-memory word-address width (64 words).
REQ-003 SHALL have parameter BUF_DEPTH, 2, fetch-buffer entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port mem_addr  output  MEM_AW  word address to instruction memory (combinational-read memory).
REQ-007 SHALL have port mem_data  input  32  instruction word returned for mem_addr in the same cycle.
REQ-008 SHALL have port if_valid  output  1  buffered instruction available to decode.
REQ-009 SHALL have port if_ready  input  1  decode accepts the instruction this cycle.
REQ-010 SHALL have port if_instr  output  32  instruction at buffer head.
REQ-011 SHALL have port if_pc  output  32  byte PC of if_instr.
REQ-012 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-013 SHALL have port redirect_pc  input  32  redirect target byte address.

Function
REQ-014 SHALL hold a 32-bit fetch PC; mem_addr SHALL equal pc[MEM_AW+1:2].
REQ-015 SHALL push {pc, mem_data} into the buffer and advance pc by 4 on each edge where the buffer is not full, or is full and a pop occurs that edge.
REQ-016 SHALL pop on each edge where if_valid && if_ready; if_valid/if_instr/if_pc SHALL be driven from buffer registers only (no mem_data bypass).
REQ-017 SHALL keep if_instr/if_pc stable while if_valid && !if_ready.
REQ-018 SHALL, on redirect_valid, flush all entries, suppress that edge's push and pop, and load pc with {redirect_pc[31:2],2'b00}.
REQ-019 SHALL produce the redirect target on if_valid exactly two cycles after redirect_valid is sampled (one fetch cycle, one buffer cycle).
REQ-020 SHALL give redirect priority over push and pop on the same edge.
REQ-021 SHALL wrap pc modulo 2^32; mem_addr SHALL wrap from 63 to 0 (pc 0xFC -> 0x100 -> word 0).
REQ-022 SHALL deliver instructions in strict fetch order with no loss or duplication; if_instr SHALL read 32'h0000_0013 (NOP) when empty.

Reset
REQ-023 SHALL, while rst_n low, set pc=RESET_PC, buffer empty, if_valid=0, if_instr=32'h0000_0013, if_pc=0, counters=0, immediately and regardless of clk.
REQ-024 SHALL discard in-flight entries on reset assertion mid-stream; first fetch SHALL be at the first rising edge after rst_n rises, if_valid at the second.

Configuration
REQ-025 SHALL, with FETCH_PERF_CNT_EN defined, add outputs fetch_cnt (32, pushes) and flush_cnt (32, valid entries discarded by redirect), both wrapping at 2^32.
REQ-026 SHALL, without FETCH_PERF_CNT_EN, omit both ports and counters entirely, with identical remaining behaviour.

Structure
REQ-027 SHALL take NOP encoding, instruction width 32 and default reset PC from the shared processor defines file.
REQ-028 SHALL implement the buffer as sub-module fetch_fifo (synchronous push/pop/flush, full/empty flags, async active-low reset).

Verification
REQ-029 Bench memory mem[k]=32'hA000_0000+k, if_ready=1 after reset -> if_valid from cycle 2, (if_pc,if_instr)=(0,A0000000),(4,A0000001),... one per cycle.
REQ-030 if_ready=0 for 5 cycles -> buffer fills to 2, pc stops at 8, if_instr holds A0000000; release -> A0000001, A0000002 with no gap or duplicate.
REQ-031 redirect_valid with redirect_pc=32'h0000_0042 while full -> flush, pc=0x40, if_valid low one cycle, then (0x40,A0000010).
REQ-032 redirect and if_valid&&if_ready same edge -> popped entry not counted as delivered twice, next output is target; flush_cnt (if enabled) +2 when buffer held 2.
REQ-033 Run from pc=0xF8 -> mem_addr 62,63,0,1; if_pc 0xF8,0xFC,0x100,0x104 with if_instr A000003E,A000003F,A0000000,A0000001.
REQ-034 rst_n pulsed low mid-stream between edges -> if_valid=0 and if_instr=NOP immediately; restart at RESET_PC.
